hpu_regif_cfg_addr_bank: RTL and testbench

Parametrised AXI4-lite register bank that holds CH_NB 64-bit HBM base addresses, one per pseudo-channel, in the cfg clock domain. Generalises the fixed per-PC address registers: the channel count and output width are parameters, and each 64-bit update is atomic through an LSB shadow with MSB commit. Per-channel update strobes, a lock bit, a clear-all control and a read-only info word are added. The bank sits between the shell AXI4-lite interconnect and the ct/glwe/ksk/trc memory-access masters.

---
 rtl/hpu_regif_cfg_addr_bank.sv | 225 ++++++++++++++++++++++
 tb/tb_hpu_regif_cfg_addr_bank.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_regif_cfg_addr_bank.sv
// rtl/hpu_regif_cfg_addr_bank.sv - AXI4-lite bank of per-channel 64-bit HBM base addresses
//
// Purpose: holds CH_NB 64-bit base addresses, one per pseudo-channel, in the cfg
// clock domain. Each 64-bit update is atomic: the LSB write lands in a shadow
// register and the MSB write commits {msb, shadow} to the active register.
// Optional feature macro: HPU_REGIF_ADDR_BANK_WR_CNT_EN (RO commit counter at 0x008).
//
// Ports:
//   cfg_clk, cfg_rst_n    clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*      AXI4-lite write address / data / response channels
//   s_axil_ar*/r*         AXI4-lite read address / data channels
//   mem_addr              committed address per channel, ADDR_W bits each
//   mem_addr_upd          one-cycle pulse per channel on commit
//   cfg_lock              current lock state
module hpu_regif_cfg_addr_bank #(
  parameter int CH_NB         = 16,
  parameter int ADDR_W        = 64,
  parameter int AXIL_ADD_W    = 32,
  parameter int AXIL_DATA_W   = 32,
  parameter int VERSION_MAJOR = 2,
  parameter int VERSION_MINOR = 1
) (
  input  logic                    cfg_clk,
  input  logic                    cfg_rst_n,
  input  logic [AXIL_ADD_W-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]  s_axil_wdata,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [AXIL_ADD_W-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [AXIL_DATA_W-1:0]  s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [CH_NB*ADDR_W-1:0] mem_addr,
  output logic [CH_NB-1:0]        mem_addr_upd,
  output logic                    cfg_lock
);

  if (CH_NB < 1 || CH_NB > 32) begin : g_bad_ch_nb
    $fatal(1, "CH_NB out of range 1..32");
  end
  if (ADDR_W < 1 || ADDR_W > 64) begin : g_bad_addr_w
    $fatal(1, "ADDR_W out of range 1..64");
  end
  if (AXIL_DATA_W != 32 || AXIL_ADD_W < 12) begin : g_bad_axil
    $fatal(1, "AXIL_DATA_W must be 32 and AXIL_ADD_W at least 12");
  end

  localparam int CH_W = (CH_NB > 1) ? $clog2(CH_NB) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [31:0] INFO_WORD  = {8'(VERSION_MAJOR), 8'(VERSION_MINOR), 8'(ADDR_W), 8'(CH_NB)};

  typedef enum logic [2:0] {REG_INFO, REG_CTRL, REG_WRCNT, REG_LSB, REG_MSB, REG_NONE} reg_kind_e;

  // Word index decode: 0 INFO, 1 CTRL, 2 WR_CNT, 4+2i LSB, 5+2i MSB.
  function automatic reg_kind_e decode_kind(input logic [9:0] idx);
    logic [9:0] ch;
    ch = (idx - 10'd4) >> 1;
    if (idx == 10'd0) return REG_INFO;
    else if (idx == 10'd1) return REG_CTRL;
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
    else if (idx == 10'd2) return REG_WRCNT;
`endif
    else if (idx >= 10'd4 && ch < 10'(CH_NB)) return idx[0] ? REG_MSB : REG_LSB;
    else return REG_NONE;
  endfunction

  logic             ready_en_q;
  logic             aw_full_q, w_full_q;
  logic [9:0]       aw_idx_q;
  logic [31:0]      w_data_q;
  logic [63:0]      active_q [CH_NB];
  logic [31:0]      shadow_q [CH_NB];
  logic             lock_q;
  logic [CH_NB-1:0] upd_q;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
  logic [31:0]      wr_cnt_q;
`endif

  logic             wr_go;
  reg_kind_e        wr_kind, rd_kind;
  logic [CH_W-1:0]  wr_sel, rd_sel;
  logic [1:0]       wr_resp, rd_resp;
  logic [31:0]      rd_data;
  logic             unused_addr_bits;

  // Address bits outside [11:2] are ignored by design.
  assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

  // ready_en_q holds all readies low during reset and the first cycle after it.
  assign s_axil_awready = ready_en_q & ~aw_full_q & ~bvalid_q;
  assign s_axil_wready  = ready_en_q & ~w_full_q & ~bvalid_q;
  assign s_axil_arready = ready_en_q & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign mem_addr_upd   = upd_q;
  assign cfg_lock       = lock_q;

  for (genvar g = 0; g < CH_NB; g++) begin : g_out
    assign mem_addr[g*ADDR_W +: ADDR_W] = active_q[g][ADDR_W-1:0];
  end

  assign wr_go = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    wr_kind = decode_kind(aw_idx_q);
    wr_sel  = CH_W'((aw_idx_q - 10'd4) >> 1);
    wr_resp = RESP_OKAY;
    case (wr_kind)
      REG_CTRL:         wr_resp = RESP_OKAY;
      REG_LSB, REG_MSB: wr_resp = lock_q ? RESP_SLVERR : RESP_OKAY;
      REG_NONE:         wr_resp = RESP_DECERR;
      default:          wr_resp = RESP_SLVERR;  // INFO and WR_CNT are read-only
    endcase
  end

  always_comb begin
    rd_kind = decode_kind(s_axil_araddr[11:2]);
    rd_sel  = CH_W'((s_axil_araddr[11:2] - 10'd4) >> 1);
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_kind)
      REG_INFO:  rd_data = INFO_WORD;
      REG_CTRL:  rd_data = {31'b0, lock_q};
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
      REG_WRCNT: rd_data = wr_cnt_q;
`endif
      REG_LSB:   rd_data = active_q[rd_sel][31:0];
      REG_MSB:   rd_data = active_q[rd_sel][63:32];
      default:   rd_resp = RESP_DECERR;
    endcase
  end

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      ready_en_q <= 1'b0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      lock_q     <= 1'b0;
      upd_q      <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      for (int i = 0; i < CH_NB; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
      wr_cnt_q   <= '0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      upd_q      <= '0;

      if (s_axil_awvalid && s_axil_awready) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[11:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axil_wdata;
      end
      if (s_axil_bvalid && s_axil_bready) bvalid_q <= 1'b0;

      if (wr_go) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_resp;
        case (wr_kind)
          REG_CTRL: begin
            // Clear and lock in one write: clearing never depends on lock,
            // so both take effect together with clear ordered first.
            lock_q <= w_data_q[0];
            if (w_data_q[1]) begin
              for (int i = 0; i < CH_NB; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
              end
              upd_q <= '1;
            end
          end
          REG_LSB: if (!lock_q) shadow_q[wr_sel] <= w_data_q;
          REG_MSB: if (!lock_q) begin
            active_q[wr_sel] <= {w_data_q, shadow_q[wr_sel]};
            upd_q[wr_sel]    <= 1'b1;
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
            wr_cnt_q         <= wr_cnt_q + 32'd1;
`endif
          end
          default: ;
        endcase
      end

      // Read data is captured from current state, so a same-cycle write is not visible.
      if (s_axil_arvalid && s_axil_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (s_axil_rvalid && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpu_regif_cfg_addr_bank.sv
// tb/tb_hpu_regif_cfg_addr_bank.sv - self-checking bench for hpu_regif_cfg_addr_bank
module tb_hpu_regif_cfg_addr_bank;
  localparam int CH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, lock;
  logic [1:0]    bresp, rresp;
  logic [CH*64-1:0] mem;
  logic [CH-1:0] upd;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_active [CH];
  logic [31:0] m_shadow [CH];
  logic        m_lock;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  hpu_regif_cfg_addr_bank dut (
    .cfg_clk(clk), .cfg_rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .mem_addr(mem), .mem_addr_upd(upd), .cfg_lock(lock)
  );

  function automatic void m_reset();
    for (int i = 0; i < CH; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_lock = 1'b0;
    m_cnt  = '0;
  endfunction

  function automatic logic [CH*64-1:0] m_mem();
    logic [CH*64-1:0] v;
    for (int i = 0; i < CH; i++) v[i*64 +: 64] = m_active[i];
    return v;
  endfunction

  function automatic void m_write(input logic [31:0] addr, input logic [31:0] data,
                                  output logic [1:0] resp, output logic [CH-1:0] eupd);
    int off, ch;
    off  = int'(addr[11:0]) & 'hFFC;
    resp = 2'b00;
    eupd = '0;
    if (off == 0) resp = 2'b10;
    else if (off == 4) begin
      if (data[1]) begin
        for (int i = 0; i < CH; i++) begin
          m_active[i] = '0;
          m_shadow[i] = '0;
        end
        eupd = '1;
      end
      m_lock = data[0];
    end else if (off == 8) begin
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
      resp = 2'b10;
`else
      resp = 2'b11;
`endif
    end else if (off >= 16 && off < 16 + 8 * CH) begin
      ch = (off - 16) / 8;
      if (m_lock) resp = 2'b10;
      else if (off % 8 == 0) m_shadow[ch] = data;
      else begin
        m_active[ch] = {data, m_shadow[ch]};
        eupd[ch] = 1'b1;
        m_cnt = m_cnt + 32'd1;
      end
    end else resp = 2'b11;
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp);
    int off, ch;
    off  = int'(addr[11:0]) & 'hFFC;
    data = '0;
    resp = 2'b00;
    if (off == 0) data = {8'd2, 8'd1, 8'd64, 8'd16};
    else if (off == 4) data = {31'b0, m_lock};
`ifdef HPU_REGIF_ADDR_BANK_WR_CNT_EN
    else if (off == 8) data = m_cnt;
`endif
    else if (off >= 16 && off < 16 + 8 * CH) begin
      ch   = (off - 16) / 8;
      data = (off % 8 == 4) ? m_active[ch][63:32] : m_active[ch][31:0];
    end else resp = 2'b11;
  endfunction

  // Bus drivers: entered and left just after a falling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp,
                           output logic [CH-1:0] upd_b, output logic [CH-1:0] upd_n);
    bit ta, tw;
    int n = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      ta = awvalid && awready;
      tw = wvalid && wready;
      @(negedge clk);
      if (ta) awvalid = 1'b0;
      if (tw) wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    resp  = bresp;
    upd_b = upd;
    @(negedge clk);
    upd_n = upd;
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL bus_write_timeout addr=%h", addr);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output bit lat_ok);
    bit ta = 1'b0;
    int n = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!ta && n < 50) begin ta = arready; @(negedge clk); n++; end
    arvalid = 1'b0;
    lat_ok  = rvalid;
    data    = rdata;
    resp    = rresp;
    @(negedge clk);
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL bus_read_timeout addr=%h", addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got=%b exp=00000", {awready, wready, arready, bvalid, rvalid});
    end
    rst_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (mem !== '0 || upd !== '0 || lock !== 1'b0) begin
      errors++; $display("FAIL reset_outputs mem=%h upd=%h lock=%b exp all 0", mem, upd, lock);
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL idle_ready got=%b exp=111", {awready, wready, arready});
    end
  endtask

  task automatic test_info();
    logic [31:0] d; logic [1:0] r; bit lat;
    bus_read(32'h000, d, r, lat);
    checks++;
    if (d !== 32'h0201_4010 || r !== 2'b00 || lat !== 1'b1) begin
      errors++; $display("FAIL info got=%h/%b/%b exp=02014010/00/1", d, r, lat);
    end
  endtask

  task automatic test_lsb_msb();
    logic [31:0] d; logic [1:0] r, er; logic [CH-1:0] ub, un, eu; bit lat;
    bus_write(32'h010, 32'hDEAD_BEEF, r, ub, un);
    m_write(32'h010, 32'hDEAD_BEEF, er, eu);
    checks++;
    if (r !== er || mem[63:0] !== 64'h0 || ub !== '0) begin
      errors++; $display("FAIL lsb_only resp=%b mem0=%h upd=%h exp %b/0/0", r, mem[63:0], ub, er);
    end
    bus_write(32'h014, 32'h0000_0001, r, ub, un);
    m_write(32'h014, 32'h0000_0001, er, eu);
    checks++;
    if (mem[63:0] !== 64'h1_DEAD_BEEF || mem !== m_mem()) begin
      errors++; $display("FAIL msb_commit mem0=%h exp=00000001deadbeef", mem[63:0]);
    end
    checks++;
    if (ub !== 16'h0001 || un !== 16'h0000 || eu !== 16'h0001) begin
      errors++; $display("FAIL commit_pulse upd=%h next=%h exp=0001/0000", ub, un);
    end
    bus_read(32'h010, d, r, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      errors++; $display("FAIL lsb_readback got=%h/%b exp=deadbeef/00", d, r);
    end
  endtask

  task automatic test_order();
    logic [31:0] a [2]; logic [31:0] d [2]; logic [1:0] er; logic [CH-1:0] eu;
    bit ta, tw, held, quiet;
    int n;
    a[0] = 32'h018; a[1] = 32'h01C; d[0] = $urandom; d[1] = $urandom;
    for (int k = 0; k < 2; k++) begin
      awaddr = a[k]; wdata = d[k]; bready = 1'b0; wvalid = 1'b1; awvalid = (k == 1); n = 0;
      if (k == 0) begin
        for (int c = 0; c < 3; c++) begin
          tw = wvalid && wready;
          @(negedge clk);
          if (tw) wvalid = 1'b0;
        end
      end
      awvalid = 1'b1;
      while ((awvalid || wvalid) && n < 50) begin
        ta = awvalid && awready;
        tw = wvalid && wready;
        @(negedge clk);
        if (ta) awvalid = 1'b0;
        if (tw) wvalid = 1'b0;
        n++;
      end
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      m_write(a[k], d[k], er, eu);
      held = bvalid && !awready && !wready;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (!(bvalid && !awready && !wready)) held = 1'b0;
      end
      checks++;
      if (n >= 50 || !held || bresp !== er) begin
        errors++; $display("FAIL order_hold k=%0d held=%b resp=%b exp held=1 resp=%b", k, held, bresp, er);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      quiet = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (bvalid) quiet = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (!quiet) begin
        errors++; $display("FAIL order_single_b k=%0d bvalid reasserted, exp single response", k);
      end
    end
    bready = 1'b1;
    checks++;
    if (mem !== m_mem() || mem[127:64] !== {d[1], d[0]}) begin
      errors++; $display("FAIL order_commit mem1=%h exp=%h", mem[127:64], {d[1], d[0]});
    end
  endtask

  task automatic test_lock();
    logic [1:0] r, er; logic [CH-1:0] ub, un, eu;
    bus_write(32'h004, 32'h1, r, ub, un);
    m_write(32'h004, 32'h1, er, eu);
    checks++;
    if (r !== er || lock !== 1'b1) begin
      errors++; $display("FAIL lock_set resp=%b lock=%b exp=%b/1", r, lock, er);
    end
    bus_write(32'h01C, $urandom, r, ub, un);
    m_write(32'h01C, 32'h0, er, eu);
    checks++;
    if (r !== 2'b10 || er !== 2'b10 || mem !== m_mem() || ub !== '0) begin
      errors++; $display("FAIL locked_write resp=%b mem1=%h exp=10/%h", r, mem[127:64], m_active[1]);
    end
    bus_write(32'h004, 32'h2, r, ub, un);
    m_write(32'h004, 32'h2, er, eu);
    checks++;
    if (mem !== '0 || ub !== 16'hFFFF || un !== 16'h0 || lock !== 1'b0 || r !== er) begin
      errors++; $display("FAIL clear_all mem=%h upd=%h next=%h lock=%b exp 0/ffff/0/0", mem, ub, un, lock);
    end
  endtask

  task automatic test_decerr();
    logic [31:0] rd_addr [3]; logic [31:0] wr_addr [2];
    logic [31:0] d, ed; logic [1:0] r, er; logic [CH-1:0] ub, un, eu; bit lat;
    rd_addr[0] = 32'h00C; rd_addr[1] = 32'h200; rd_addr[2] = 32'h008;
    wr_addr[0] = 32'h000; wr_addr[1] = 32'h200;
    for (int i = 0; i < 3; i++) begin
      bus_read(rd_addr[i], d, r, lat);
      m_read(rd_addr[i], ed, er);
      checks++;
      if (d !== ed || r !== er) begin
        errors++; $display("FAIL decode_read addr=%h got=%h/%b exp=%h/%b", rd_addr[i], d, r, ed, er);
      end
    end
    for (int i = 0; i < 2; i++) begin
      bus_write(wr_addr[i], $urandom, r, ub, un);
      m_write(wr_addr[i], 32'h0, er, eu);
      checks++;
      if (r !== er || mem !== m_mem()) begin
        errors++; $display("FAIL decode_write addr=%h resp=%b exp=%b", wr_addr[i], r, er);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] nd, od, ed; logic [1:0] r, er; logic [CH-1:0] ub, un, eu;
    od = $urandom; nd = ~od;
    bus_write(32'h024, od, r, ub, un);
    m_write(32'h024, od, er, eu);
    m_read(32'h024, ed, er);
    awaddr = 32'h024; wdata = nd; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h024; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== ed) begin
      errors++; $display("FAIL same_cycle rvalid=%b bvalid=%b rdata=%h exp 1/1/%h", rvalid, bvalid, rdata, ed);
    end
    m_write(32'h024, nd, er, eu);
    @(negedge clk);
    checks++;
    if (mem !== m_mem()) begin
      errors++; $display("FAIL same_cycle_commit mem2=%h exp=%h", mem[191:128], m_active[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, d, ed; logic [1:0] r, er; logic [CH-1:0] ub, un, eu;
    bit lat; int op, ch, msb;
    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 9); ch = $urandom_range(0, CH - 1); msb = $urandom_range(0, 1);
      data = $urandom;
      addr = 32'(16 + 8 * ch + 4 * msb) | ($urandom & 32'hFFFF_F003);
      if (op == 9) begin
        addr = 32'h4 | ($urandom & 32'hFFFF_F003);
        data = {30'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0)};
      end
      if (op == 8) addr = 32'($urandom_range(0, 4095));
      if (op >= 7 && op <= 8) begin
        bus_read(addr, d, r, lat);
        m_read(addr, ed, er);
        checks++;
        if (d !== ed || r !== er || lat !== 1'b1) begin
          errors++; $display("FAIL rand_read addr=%h got=%h/%b/%b exp=%h/%b/1", addr, d, r, lat, ed, er);
        end
      end else begin
        bus_write(addr, data, r, ub, un);
        m_write(addr, data, er, eu);
        checks++;
        if (r !== er || lock !== m_lock) begin
          errors++; $display("FAIL rand_wresp addr=%h resp=%b lock=%b exp=%b/%b", addr, r, lock, er, m_lock);
        end
        checks++;
        if (mem !== m_mem()) begin
          errors++; $display("FAIL rand_mem addr=%h ch=%0d got=%h exp=%h", addr, ch,
                             mem[ch*64 +: 64], m_active[ch]);
        end
        checks++;
        if (ub !== eu || un !== '0) begin
          errors++; $display("FAIL rand_upd addr=%h upd=%h next=%h exp=%h/0", addr, ub, un, eu);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit lat;
    awaddr = 32'h014; wdata = $urandom; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bvalid !== 1'b0 || mem !== '0 || upd !== '0 || {awready, wready, arready} !== 3'b0) begin
      errors++; $display("FAIL reset_mid bvalid=%b mem=%h ready=%b exp all 0", bvalid, mem,
                         {awready, wready, arready});
    end
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL reset_idle bvalid=%b ready=%b exp 0/111", bvalid, {awready, wready, arready});
    end
    bus_read(32'h014, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_regs got=%h/%b exp=0/00", d, r);
    end
  endtask

  task automatic test_wr_cnt();
    logic [31:0] addr, d, ed; logic [1:0] r, er; logic [CH-1:0] ub, un, eu; bit lat;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(16 + 8 * $urandom_range(0, CH - 1) + 4);
      bus_write(addr, $urandom, r, ub, un);
      m_write(addr, 32'h0, er, eu);
    end
    bus_write(32'h004, 32'h1, r, ub, un);
    m_write(32'h004, 32'h1, er, eu);
    bus_write(32'h014, $urandom, r, ub, un);
    m_write(32'h014, 32'h0, er, eu);
    bus_write(32'h004, 32'h0, r, ub, un);
    m_write(32'h004, 32'h0, er, eu);
    bus_read(32'h008, d, r, lat);
    m_read(32'h008, ed, er);
    checks++;
    if (d !== ed || r !== er) begin
      errors++; $display("FAIL wr_cnt got=%h/%b exp=%h/%b", d, r, ed, er);
    end
  endtask

  initial begin
    awaddr = '0; wdata = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
    m_reset();
    test_reset();
    test_info();
    test_lsb_msb();
    test_order();
    test_lock();
    test_decerr();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_wr_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
